// File: rtl/control_multi_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: opcodes, states, mux codes and the
// packed control word handed from the state decoder to the top.
package control_multi_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_RWB    = 4'd7,
        ST_BEQ    = 4'd8,
        ST_JMP    = 4'd9,
        ST_ADDIEX = 4'd10,
        ST_ADDIWB = 4'd11,
        ST_BNE    = 4'd12,
        ST_ERROR  = 4'd13
    } state_t;

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SW   = 6'd43;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_JMP  = 6'd5;
    localparam logic [5:0] OP_ADDI = 6'd6;
    localparam logic [5:0] OP_BNE  = 6'd7;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_4    = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_write_cond_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // States that hold on the memory handshake and count toward the timeout trap.
    function automatic logic is_mem_wait(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
    endfunction

endpackage

// File: rtl/control_multi_decode.sv
// State -> control word decoder; purely combinational, zero latency. Only FETCH looks at
// mem_ready, so IR/PC load exactly on the cycle memory completes.
module control_multi_decode
    import control_multi_pkg::*;
(
    input  state_t state_i,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (state_i)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_4;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            ST_DECODE: ctrl.alu_src_b = SRCB_IMM2;
            ST_MEMADR, ST_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            ST_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            ST_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            ST_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            ST_BEQ, ST_BNE: begin
                ctrl.alu_src_a        = 1'b1;
                ctrl.alu_op           = ALUOP_SUB;
                ctrl.pc_source        = PCSRC_ALUOUT;
                ctrl.pc_write_cond    = (state_i == ST_BEQ);
                ctrl.pc_write_cond_ne = (state_i == ST_BNE);
            end
            ST_JMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            ST_ADDIWB: ctrl.reg_write = 1'b1;
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/control_multi.sv
// Multi-cycle MIPS control FSM: 3-5 cycles per instruction plus one per memory not-ready cycle;
// memory stalls hold state, and a stall longer than MEM_TIMEOUT traps into ERROR until reset.
module control_multi
    import control_multi_pkg::*;
#(
    parameter int OP_W        = 6,
    parameter int TMO_W       = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] opcode,
    input  logic            mem_ready,
    output logic            PCWrite,
    output logic            PCWriteCond,
    output logic            PCWriteCondNe,
    output logic            IorD,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic            MemtoReg,
    output logic            RegDst,
    output logic            RegWrite,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      ALUOp,
    output logic [1:0]      PCSource,
    output logic            err,
    output logic [1:0]      err_code,
    output logic [3:0]      state
);

    state_t           state_q, state_d;
    logic [TMO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    ctrl_t            ctrl_raw, ctrl;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        err_d      = err_q;
        err_code_d = err_code_q;

        if (is_mem_wait(state_q) && !mem_ready) begin
            if (wait_cnt_q == TMO_W'(MEM_TIMEOUT)) begin
                state_d    = ST_ERROR;
                err_d      = 1'b1;
                err_code_d = ERR_TIMEOUT;
            end else begin
                wait_cnt_d = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + TMO_W'(1);
            end
        end else begin
            unique case (state_q)
                ST_FETCH: state_d = ST_DECODE;
                ST_DECODE: begin
                    if (opcode == OP_W'(OP_LW) || opcode == OP_W'(OP_SW)) state_d = ST_MEMADR;
                    else if (opcode == OP_W'(OP_R))    state_d = ST_EXEC;
                    else if (opcode == OP_W'(OP_BEQ))  state_d = ST_BEQ;
                    else if (opcode == OP_W'(OP_BNE))  state_d = ST_BNE;
                    else if (opcode == OP_W'(OP_JMP))  state_d = ST_JMP;
                    else if (opcode == OP_W'(OP_ADDI)) state_d = ST_ADDIEX;
                    else begin
                        state_d    = ST_ERROR;
                        err_d      = 1'b1;
                        err_code_d = ERR_ILLEGAL;
                    end
                end
                // IR still holds the decoded instruction, so opcode splits LW from SW here.
                ST_MEMADR: state_d = (opcode == OP_W'(OP_SW)) ? ST_MEMWR : ST_MEMRD;
                ST_MEMRD:  state_d = ST_MEMWB;
                ST_EXEC:   state_d = ST_RWB;
                ST_ADDIEX: state_d = ST_ADDIWB;
                ST_MEMWB, ST_MEMWR, ST_RWB, ST_BEQ, ST_BNE, ST_JMP, ST_ADDIWB:
                    state_d = ST_FETCH;
                ST_ERROR:  state_d = ST_ERROR;
                default:   state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_FETCH;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    control_multi_decode u_decode (
        .state_i   (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl_raw)
    );

    // FETCH strobes depend on mem_ready directly, so gate with reset to keep them quiet.
    assign ctrl = reset ? '0 : ctrl_raw;

    assign PCWrite       = ctrl.pc_write;
    assign PCWriteCond   = ctrl.pc_write_cond;
    assign PCWriteCondNe = ctrl.pc_write_cond_ne;
    assign IorD          = ctrl.iord;
    assign MemRead       = ctrl.mem_read;
    assign MemWrite      = ctrl.mem_write;
    assign IRWrite       = ctrl.ir_write;
    assign MemtoReg      = ctrl.mem_to_reg;
    assign RegDst        = ctrl.reg_dst;
    assign RegWrite      = ctrl.reg_write;
    assign ALUSrcA       = ctrl.alu_src_a;
    assign ALUSrcB       = ctrl.alu_src_b;
    assign ALUOp         = ctrl.alu_op;
    assign PCSource      = ctrl.pc_source;
    assign err           = err_q;
    assign err_code      = err_code_q;
    assign state         = state_q;

endmodule
